// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/LM-SM sequencing and flag history for an NSTAGE pipeline; PIPE_CTRL_PERF_EN adds saturating stall/flush counters
module pipeline_hazard_ctrl #(
  parameter int NSTAGE     = 5,
  parameter int REG_AW     = 3,
  parameter int HIST_DEPTH = 3,
  parameter int MULTI_MAX  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NSTAGE-1:0]            stg_valid,
  input  logic [NSTAGE-1:0]            stg_wr,
  input  logic [NSTAGE-1:0]            stg_load,
  input  logic [NSTAGE*REG_AW-1:0]     stg_dest,
  input  logic [REG_AW-1:0]            id_src_a,
  input  logic [REG_AW-1:0]            id_src_b,
  input  logic                         id_use_a,
  input  logic                         id_use_b,
  input  logic                         br_taken,
  input  logic [$clog2(NSTAGE)-1:0]    br_stage,
  input  logic                         multi_start,
  input  logic [MULTI_MAX-1:0]         multi_mask,
  input  logic                         flag_upd,
  input  logic                         new_carry,
  input  logic                         new_zero,
  output logic [NSTAGE-1:0]            stg_en,
  output logic [NSTAGE-1:0]            stg_clr,
  output logic                         pc_en,
  output logic                         multi_busy,
  output logic                         multi_last,
  output logic [$clog2(MULTI_MAX)-1:0] multi_idx,
  output logic [HIST_DEPTH-1:0]        carry_hist,
  output logic [HIST_DEPTH-1:0]        zero_hist,
  output logic [15:0]                  stall_cnt,
  output logic [15:0]                  flush_cnt
);
  localparam int IW = $clog2(MULTI_MAX);
  localparam logic [MULTI_MAX-1:0] ONE = MULTI_MAX'(1);
  typedef enum logic {IDLE, SEQ} state_t;
  state_t state_q, state_d;
  logic [MULTI_MAX-1:0] rem_q, rem_d, cur, rest;
  logic [HIST_DEPTH-1:0] carry_hist_q, carry_hist_d, zero_hist_q, zero_hist_d;
  logic [REG_AW-1:0] dest2;
  logic [IW-1:0] low;
  logic flush, lu, issue, one, stall;
  // hazard detection, micro-op selection, output priority and next state
  always_comb begin
    flush = br_taken && (int'(br_stage) < NSTAGE);
    dest2 = stg_dest[2*REG_AW +: REG_AW];
    lu = stg_valid[2] && stg_load[2] && stg_wr[2] && stg_valid[1] &&
         ((id_use_a && id_src_a == dest2) || (id_use_b && id_src_b == dest2));
    cur = (state_q == SEQ) ? rem_q : multi_mask;
    rest = cur & (cur - ONE);
    one = rest == '0;
    low = '0;
    for (int i = MULTI_MAX - 1; i >= 0; i--) if (cur[i]) low = IW'(i);
    issue = !flush && !lu && ((state_q == SEQ) || (multi_start && stg_valid[1] && multi_mask != '0));
    stall = !flush && (lu || (issue && !one));
    stg_en = '1;
    stg_clr = '0;
    pc_en = 1'b1;
    multi_busy = 1'b0;
    multi_last = 1'b0;
    multi_idx = '0;
    state_d = state_q;
    rem_d = rem_q;
    if (!rst_n) begin
      stg_en = '0;
      stg_clr = '1;
      pc_en = 1'b0;
    end else if (flush) begin
      for (int k = 0; k < NSTAGE; k++) stg_clr[k] = k <= int'(br_stage);
      state_d = IDLE;
    end else if (lu) begin
      pc_en = 1'b0;
      stg_en[1:0] = 2'b00;
      stg_clr[2] = 1'b1;
    end else if (issue) begin
      multi_busy = 1'b1;
      multi_last = one;
      multi_idx = low;
      pc_en = one;
      stg_en[1:0] = one ? 2'b11 : 2'b00;
      state_d = one ? IDLE : SEQ;
      rem_d = one ? rem_q : rest;
    end
    carry_hist_d = flag_upd ? HIST_DEPTH'({carry_hist_q, new_carry}) : carry_hist_q;
    zero_hist_d = flag_upd ? HIST_DEPTH'({zero_hist_q, new_zero}) : zero_hist_q;
  end
  // FSM, remaining mask and flag history registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q <= '0;
      carry_hist_q <= '0;
      zero_hist_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      carry_hist_q <= carry_hist_d;
      zero_hist_q <= zero_hist_d;
    end
  end
  assign carry_hist = carry_hist_q;
  assign zero_hist = zero_hist_q;
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  // saturating performance counters
  always_comb begin
    stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    flush_cnt_d = (flush && flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
  end
  // counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors with a scoreboard queue checked by a negedge monitor
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] stg_valid, stg_wr, stg_load;
  logic [14:0] stg_dest;
  logic [2:0] id_src_a, id_src_b;
  logic id_use_a, id_use_b, br_taken;
  logic [2:0] br_stage;
  logic multi_start;
  logic [7:0] multi_mask;
  logic flag_upd, new_carry, new_zero;
  logic [4:0] stg_en, stg_clr;
  logic pc_en, multi_busy, multi_last;
  logic [2:0] multi_idx, carry_hist, zero_hist;
  logic [15:0] stall_cnt, flush_cnt;
  typedef struct {
    string nm;
    logic [4:0] en, clr;
    logic pc, busy, last;
    logic [2:0] idx, ch, zh;
    logic [15:0] sc, fc;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  logic [2:0] m_ch = '0, m_zh = '0;
  logic [15:0] m_sc = '0, m_fc = '0;
  pipeline_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stg_valid(stg_valid), .stg_wr(stg_wr), .stg_load(stg_load),
    .stg_dest(stg_dest), .id_src_a(id_src_a), .id_src_b(id_src_b), .id_use_a(id_use_a),
    .id_use_b(id_use_b), .br_taken(br_taken), .br_stage(br_stage), .multi_start(multi_start),
    .multi_mask(multi_mask), .flag_upd(flag_upd), .new_carry(new_carry), .new_zero(new_zero),
    .stg_en(stg_en), .stg_clr(stg_clr), .pc_en(pc_en), .multi_busy(multi_busy),
    .multi_last(multi_last), .multi_idx(multi_idx), .carry_hist(carry_hist),
    .zero_hist(zero_hist), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  // monitor: compare DUT outputs against the queued expectation mid-cycle
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (stg_en !== e.en || stg_clr !== e.clr || pc_en !== e.pc || multi_busy !== e.busy ||
          multi_last !== e.last || multi_idx !== e.idx || carry_hist !== e.ch ||
          zero_hist !== e.zh || stall_cnt !== e.sc || flush_cnt !== e.fc) begin
        n_bad++;
        $display("FAIL %s: got en=%b clr=%b pc=%b busy=%b last=%b idx=%0d ch=%b zh=%b sc=%h fc=%h, want en=%b clr=%b pc=%b busy=%b last=%b idx=%0d ch=%b zh=%b sc=%h fc=%h",
                 e.nm, stg_en, stg_clr, pc_en, multi_busy, multi_last, multi_idx, carry_hist,
                 zero_hist, stall_cnt, flush_cnt, e.en, e.clr, e.pc, e.busy, e.last, e.idx,
                 e.ch, e.zh, e.sc, e.fc);
      end
    end
  end
  task automatic idle();
    stg_valid = '0; stg_wr = '0; stg_load = '0; stg_dest = '0;
    id_src_a = '0; id_src_b = '0; id_use_a = 0; id_use_b = 0;
    br_taken = 0; br_stage = '0; multi_start = 0; multi_mask = '0;
    flag_upd = 0; new_carry = 0; new_zero = 0;
  endtask
  task automatic hazard();
    stg_valid = 5'b00111; stg_load = 5'b00100; stg_wr = 5'b00100;
    stg_dest = 15'(3 << 6); id_src_a = 3'd3; id_use_a = 1;
  endtask
  task automatic chk(input string nm, input logic [4:0] en, input logic [4:0] clr, input logic pc,
                     input logic busy, input logic last, input logic [2:0] idx, input bit si, input bit fi);
    exp_t e;
    if (!rst_n) begin m_ch = '0; m_zh = '0; m_sc = '0; m_fc = '0; end
    e.nm = nm; e.en = en; e.clr = clr; e.pc = pc; e.busy = busy; e.last = last; e.idx = idx;
    e.ch = m_ch; e.zh = m_zh;
`ifdef PIPE_CTRL_PERF_EN
    e.sc = m_sc; e.fc = m_fc;
`else
    e.sc = '0; e.fc = '0;
`endif
    q.push_back(e);
    @(posedge clk);
    if (rst_n) begin
      if (flag_upd) begin m_ch = {m_ch[1:0], new_carry}; m_zh = {m_zh[1:0], new_zero}; end
      if (si && m_sc != 16'hFFFF) m_sc++;
      if (fi && m_fc != 16'hFFFF) m_fc++;
    end
    #1;
  endtask
  task automatic run(input string nm);
    chk(nm, 5'b11111, 5'b00000, 1, 0, 0, 0, 0, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n = 0; idle(); flag_upd = 1; new_carry = 1;
    @(posedge clk); #1;
    chk("reset", 5'b00000, 5'b11111, 0, 0, 0, 0, 0, 0);
    rst_n = 1;
    chk("rst_release", 5'b11111, 5'b00000, 1, 0, 0, 0, 0, 0);
    flag_upd = 0; new_carry = 0;
    run("run");
    hazard();
    chk("lu_a", 5'b11100, 5'b00100, 0, 0, 0, 0, 1, 0);
    stg_valid = 5'b00011;
    run("lu_cleared");
    stg_valid = 5'b00111; id_src_a = 3'd4;
    run("lu_miss");
    id_use_b = 1; id_src_b = 3'd3;
    chk("lu_b", 5'b11100, 5'b00100, 0, 0, 0, 0, 1, 0);
    br_taken = 1; br_stage = 3'd1;
    chk("flush_over_lu", 5'b11111, 5'b00011, 1, 0, 0, 0, 0, 1);
    idle(); br_taken = 1; br_stage = 3'd2;
    chk("flush2", 5'b11111, 5'b00111, 1, 0, 0, 0, 0, 1);
    br_stage = 3'd7;
    run("flush_oob");
    br_stage = 3'd4;
    chk("flush4", 5'b11111, 5'b11111, 1, 0, 0, 0, 0, 1);
    idle(); stg_valid = 5'b00010; multi_start = 1; multi_mask = 8'b1001_0100;
    chk("multi_1", 5'b11100, 5'b00000, 0, 1, 0, 3'd2, 1, 0);
    chk("multi_2", 5'b11100, 5'b00000, 0, 1, 0, 3'd4, 1, 0);
    chk("multi_3", 5'b11111, 5'b00000, 1, 1, 1, 3'd7, 0, 0);
    multi_start = 0;
    run("multi_done");
    multi_start = 1; multi_mask = 8'b0000_0001;
    chk("multi_single", 5'b11111, 5'b00000, 1, 1, 1, 3'd0, 0, 0);
    multi_mask = 8'b0;
    run("multi_zero");
    multi_mask = 8'b1001_0100;
    chk("mflush_1", 5'b11100, 5'b00000, 0, 1, 0, 3'd2, 1, 0);
    multi_start = 0; br_taken = 1; br_stage = 3'd1;
    chk("mflush_2", 5'b11111, 5'b00011, 1, 0, 0, 0, 0, 1);
    br_taken = 0;
    run("mflush_idle");
    multi_start = 1;
    chk("mrst_1", 5'b11100, 5'b00000, 0, 1, 0, 3'd2, 1, 0);
    multi_start = 0; rst_n = 0;
    chk("mrst_reset", 5'b00000, 5'b11111, 0, 0, 0, 0, 0, 0);
    rst_n = 1;
    run("mrst_idle");
    idle(); flag_upd = 1; new_carry = 1; new_zero = 0;
    run("flag_1");
    new_carry = 0; new_zero = 1;
    run("flag_2");
    new_carry = 1; new_zero = 1;
    run("flag_3");
    new_carry = 1; new_zero = 0;
    run("flag_4_sees_101");
    flag_upd = 0;
    run("flag_final_011");
`ifdef PIPE_CTRL_PERF_EN
    hazard();
    repeat (65600) @(posedge clk);
    #1;
    m_sc = 16'hFFFF;
    chk("stall_sat", 5'b11100, 5'b00100, 0, 0, 0, 0, 1, 0);
    idle();
`endif
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised pipeline control core, successor to the fixed 5-stage controller. For an N-stage in-order pipeline it generates per-register enable and clear signals from three sources: load-use stalls, taken-branch flushes and an LM/SM multi-register micro-op sequencer. It also keeps a configurable-depth history of carry and zero flags. It sits between the stage decoders and the pipeline registers; register k holds the instruction of stage k, with 0 = IF/ID.

## Interface
- NSTAGE, 5, number of pipeline registers (min 3)
- REG_AW, 3, register address width
- HIST_DEPTH, 3, flag history length
- MULTI_MAX, 8, width of LM/SM register bitmap
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- STG_VALID  in  NSTAGE  register k holds a real instruction
- STG_WR  in  NSTAGE  instruction in k writes the RF
- STG_LOAD  in  NSTAGE  instruction in k is a load
- STG_DEST  in  NSTAGE*REG_AW  destination of k, slice [k*REG_AW +: REG_AW]
- ID_SRC_A, ID_SRC_B  in  REG_AW  sources of instruction in register 1
- ID_USE_A, ID_USE_B  in  1  corresponding source is read
- BR_TAKEN  in  1  branch resolved taken this cycle
- BR_STAGE  in  $clog2(NSTAGE)  register index of resolving branch
- MULTI_START  in  1  register 1 holds LM/SM
- MULTI_MASK  in  MULTI_MAX  register bitmap of that LM/SM
- FLAG_UPD, NEW_CARRY, NEW_ZERO  in  1  flag write from EX
- STG_EN  out  NSTAGE  capture enable per register
- STG_CLR  out  NSTAGE  load bubble into register at next edge
- PC_EN  out  1  PC update enable
- MULTI_BUSY, MULTI_LAST  out  1  micro-op being issued / final micro-op
- MULTI_IDX  out  $clog2(MULTI_MAX)  register index of current micro-op
- CARRY_HIST, ZERO_HIST  out  HIST_DEPTH  bit 0 newest
- STALL_CNT, FLUSH_CNT  out  16  performance counters (see Configuration)

## Operation
- Priority: reset > flush > load-use stall > multi sequence > run.
- Run: STG_EN all 1, STG_CLR all 0, PC_EN 1.
- Flush: BR_TAKEN=1 and BR_STAGE<NSTAGE. Drives STG_CLR[k]=1 for k<=BR_STAGE and PC_EN=1. Aborts any multi sequence (FSM to IDLE). BR_STAGE>=NSTAGE is ignored.
- Load-use hazard: all of STG_VALID[2], STG_LOAD[2], STG_WR[2], STG_VALID[1], and (ID_USE_A and ID_SRC_A==dest2, or ID_USE_B and ID_SRC_B==dest2). Response: PC_EN=0, STG_EN[1:0]=0, STG_CLR[2]=1; upper registers run.
- Multi FSM states are IDLE and SEQ, with a remaining-mask register.
  - In IDLE, MULTI_START with STG_VALID[1] and MASK!=0 issues the lowest set bit that cycle: MULTI_BUSY=1, MULTI_IDX set.
  - If popcount(MASK)==1, MULTI_LAST=1 with no stall.
  - Otherwise, stall PC_EN=0 and STG_EN[1:0]=0, and go to SEQ with rem = MASK minus the lowest bit.
  - In SEQ, each cycle issues the lowest bit of rem and clears it. The stall is held until the cycle rem has one bit; that cycle MULTI_LAST=1, the stall is released, and the FSM goes to IDLE.
  - MASK==0 is treated as an ordinary instruction: MULTI_BUSY stays 0.
- Flag history: on FLAG_UPD, shift left, with NEW_CARRY/NEW_ZERO entering bit 0. The oldest bit is dropped. History is independent of stalls and flushes.

## Timing
- All control outputs are combinational from inputs and state. State updates on the CLK rising edge.
- While RST_N=0:
  - STG_EN=0 and STG_CLR all 1.
  - PC_EN=0, MULTI_BUSY=0, MULTI_LAST=0, MULTI_IDX=0.
  - CARRY_HIST, ZERO_HIST and counters are 0.
  - FSM is IDLE.
- Reset mid-sequence discards rem. Reset deasserted together with FLAG_UPD: no shift until the first post-reset edge.
- Load-use stall lasts exactly 1 cycle per hazard, since the bubble clears the condition.
- An LM/SM with p set bits occupies register 1 for p cycles and inserts p-1 stall cycles.
- A flush in the same cycle as a stall or multi issue: the flush wins, with no stall asserted.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - STALL_CNT increments each cycle PC_EN=0 due to load-use or multi stall.
  - FLUSH_CNT increments each flush cycle.
  - Both are 16-bit and saturate at 16'hFFFF.
- Not defined: STALL_CNT and FLUSH_CNT are constant 0 and the counter logic is absent.

## Test plan
- Load-use stall:
  - Stimulus: STG_VALID=5'b00111, STG_LOAD[2]=1, STG_WR[2]=1, dest2=3, ID_SRC_A=3, ID_USE_A=1.
  - Required response: one cycle with PC_EN=0, STG_EN=5'b11100, STG_CLR=5'b00100.
  - Same stimulus with ID_SRC_A=4: no stall.
- Branch flush:
  - BR_TAKEN=1, BR_STAGE=2: STG_CLR=5'b00111, PC_EN=1.
  - BR_STAGE=7 (out of range) is ignored.
- Multi sequence:
  - MULTI_MASK=8'b1001_0100 gives MULTI_IDX 2,4,7 on 3 consecutive cycles.
  - PC_EN=0 for the first 2 cycles; MULTI_LAST=1 only on idx 7.
  - MASK=8'b0000_0001 gives a single cycle with idx 0 and LAST=1, no stall.
- Flush mid-sequence and reset:
  - BR_TAKEN on the second micro-op: FSM goes to IDLE, MULTI_BUSY=0 next cycle.
  - RST_N low mid-sequence: all outputs take their reset values immediately.
- Flag history: FLAG_UPD with carry 1,0,1 gives CARRY_HIST=3'b101. A fourth update with 1 gives 3'b011.
- Counters, PIPE_CTRL_PERF_EN defined: 2 load-use stalls and 1 flush give STALL_CNT=2 and FLUSH_CNT=1. Forced 70000 stall cycles hold STALL_CNT at 16'hFFFF.
